// File: rtl/layer_sequencer_if.sv
// Handshake bundle between a layer sequencer, its neuron array and the stream neighbours.
// Pure wiring, no latency.
// Ready/valid on the sample and output streams; per-neuron valid pulses toward the layer.
interface layer_sequencer_if #(
  parameter int NN = 30,
  parameter int DW = 16
);
  logic [DW-1:0]    s_data;
  logic             s_valid;
  logic             s_ready;
  logic [NN*DW-1:0] layer_x_in;
  logic [NN-1:0]    layer_x_valid;
  logic [NN*DW-1:0] layer_x_out;
  logic [NN-1:0]    layer_o_valid;
  logic [DW-1:0]    m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  // Sequencer side: consumes the sample stream, drives the layer, produces the output stream.
  modport master (
    input  s_data, s_valid,
    output s_ready,
    output layer_x_in, layer_x_valid,
    input  layer_x_out, layer_o_valid,
    output m_data, m_valid, m_last,
    input  m_ready
  );

  // Environment side: sample source, neuron array and downstream sink.
  modport slave (
    output s_data, s_valid,
    input  s_ready,
    input  layer_x_in, layer_x_valid,
    output layer_x_out, layer_o_valid,
    input  m_data, m_valid, m_last,
    output m_ready
  );
endinterface

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: broadcast NUM_WEIGHT samples, collect NN outputs, replay them.
// Latency: accepted sample reaches the layer 1 cycle later; outputs stream from DRAIN entry.
// Backpressure: s_ready only in FEED; DRAIN holds m_data/m_valid while m_ready is low.
module layer_sequencer #(
  parameter int NN         = 30,
  parameter int NUM_WEIGHT = 784,
  parameter int DW         = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               rst,
  layer_sequencer_if.master  bus,
  output logic               busy,
  output logic [1:0]         err
);

  localparam int CW = $clog2(NUM_WEIGHT + 1);
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] FEED  = 2'b00;
  localparam logic [1:0] WAIT  = 2'b01;
  localparam logic [1:0] DRAIN = 2'b10;

  logic [1:0]    state;
  logic [CW-1:0] in_cnt;
  logic [IW-1:0] idx;
  logic [TW-1:0] wait_cnt;
  logic [NN-1:0] done;
  logic [DW-1:0] cap [NN];

  logic accept;
  logic xfer;
  logic all_done;
  logic timeout_hit;
  logic last_in;

  assign accept      = bus.s_valid & bus.s_ready;
  assign xfer        = bus.m_valid & bus.m_ready;
  assign all_done    = &done;
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));
  assign last_in     = (in_cnt == CW'(NUM_WEIGHT - 1));

  // Reset is folded into s_ready so no sample can be taken while the block is held in reset.
  assign bus.s_ready = rst & (state == FEED);
  assign bus.m_valid = (state == DRAIN);
  assign bus.m_data  = cap[idx];
  assign bus.m_last  = (state == DRAIN) & (idx == IW'(NN - 1));
  assign busy        = (state == WAIT) | (state == DRAIN);

  // Pass control: count samples in FEED, wait for completion or timeout, then walk the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FEED;
      in_cnt   <= '0;
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        FEED: begin
          if (accept) begin
            if (last_in) begin
              in_cnt   <= '0;
              wait_cnt <= '0;
              state    <= WAIT;
            end else begin
              in_cnt <= in_cnt + CW'(1);
            end
          end
        end
        WAIT: begin
          // Completion wins over a coincident timeout so a late-but-complete layer is not flagged.
          if (all_done || timeout_hit) begin
            state    <= DRAIN;
            idx      <= '0;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (bus.m_last) begin
              state <= FEED;
              idx   <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= FEED;
      endcase
    end
  end

  // Broadcast register: one-cycle valid pulse per accepted sample, data held between samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.layer_x_in    <= '0;
      bus.layer_x_valid <= '0;
    end else begin
      bus.layer_x_valid <= accept ? {NN{1'b1}} : '0;
      if (accept) begin
        bus.layer_x_in <= {NN{bus.s_data}};
      end
    end
  end

  // Output capture in WAIT; neurons missing at timeout contribute zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= '0;
      for (int k = 0; k < NN; k++) begin
        cap[k] <= '0;
      end
    end else if (state == WAIT) begin
      for (int k = 0; k < NN; k++) begin
        if (bus.layer_o_valid[k]) begin
          cap[k] <= bus.layer_x_out[k*DW +: DW];
        end else if (timeout_hit && !done[k]) begin
          cap[k] <= '0;
        end
      end
      done <= (all_done || timeout_hit) ? '0 : (done | bus.layer_o_valid);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 2'b00;
    end else begin
      if ((state == WAIT) && timeout_hit && !all_done) begin
        err[0] <= 1'b1;
      end
      if (((state == FEED) || (state == DRAIN)) && (|bus.layer_o_valid)) begin
        err[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with NN=4, NUM_WEIGHT=3, TIMEOUT=16, DW=16.
// Table of full passes plus hand-written error/reset sequences.
// A negedge monitor checks every broadcast cycle against the accepted samples.
module tb_layer_sequencer;
  localparam int NN = 4;
  localparam int NW = 3;
  localparam int TO = 16;
  localparam int DW = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy;
  logic [1:0] err;

  always #5 clk = ~clk;

  layer_sequencer_if #(.NN(NN), .DW(DW)) bus_if ();

  layer_sequencer #(.NN(NN), .NUM_WEIGHT(NW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_if),
    .busy (busy),
    .err  (err)
  );

  int errors = 0;
  int checks = 0;
  int xcnt   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Broadcast monitor: x_valid must pulse exactly one cycle after each accept, x_in must hold.
  logic        prev_acc = 1'b0;
  logic [15:0] prev_dat = '0;
  logic [15:0] last_x   = '0;
  logic        exp_xv;
  always @(negedge clk) begin
    if (!rst) begin
      exp_xv = 1'b0;
      last_x = '0;
    end else begin
      exp_xv = prev_acc;
      if (prev_acc) last_x = prev_dat;
    end
    chk("x_valid", 64'(bus_if.layer_x_valid), exp_xv ? 64'hF : 64'h0);
    chk("x_in", bus_if.layer_x_in, {4{last_x}});
    if (bus_if.layer_x_valid != '0) xcnt++;
    prev_acc = rst && bus_if.s_valid && bus_if.s_ready;
    prev_dat = bus_if.s_data;
  end

  // Arrays are packed high-to-low: {elem3, elem2, elem1, elem0}. dly=255 means never valid.
  typedef struct packed {
    logic [2:0][15:0] samp;
    logic             toggle;
    logic [3:0][7:0]  dly;
    logic [3:0][15:0] outv;
    logic [7:0]       stall_at;
    logic [7:0]       stall_len;
    logic [3:0][15:0] expm;
    logic [1:0]       exp_err;
  } vec_t;

  vec_t vec [5];

  task automatic do_reset();
    rst                  = 1'b0;
    bus_if.s_valid       = 1'b0;
    bus_if.s_data        = '0;
    bus_if.layer_o_valid = '0;
    bus_if.layer_x_out   = '0;
    bus_if.m_ready       = 1'b0;
    step();
    step();
    chk("rst_outs", {bus_if.s_ready, bus_if.m_valid, bus_if.m_last, busy, err}, 6'b0);
    chk("rst_mdata", bus_if.m_data, 16'h0);
    chk("rst_xvalid", bus_if.layer_x_valid, 4'h0);
    rst = 1'b1;
    step();
  endtask

  task automatic run_pass(input vec_t r);
    int          i, cyc, drain_c, got, maxd;
    logic        acc, prev_stall, ok;
    logic [15:0] prev_d;
    logic [15:0] gd [4];
    logic        gl [4];
    xcnt = 0;
    // Feed phase
    i   = 0;
    cyc = 0;
    while (i < NW && cyc < 40) begin
      bus_if.s_valid = r.toggle ? ~cyc[0] : 1'b1;
      bus_if.s_data  = r.samp[i];
      chk("s_ready_feed", bus_if.s_ready, 1'b1);
      acc = bus_if.s_valid && bus_if.s_ready;
      step();
      if (acc) i++;
      cyc++;
    end
    chk("feed_accepts", i, NW);
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    chk("wait_entry", {busy, bus_if.s_ready, bus_if.m_valid}, 3'b100);
    // Wait phase
    maxd = 0;
    for (int k = 0; k < NN; k++) begin
      if (r.dly[k] != 8'd255 && int'(r.dly[k]) > maxd) maxd = int'(r.dly[k]);
      bus_if.layer_x_out[k*DW +: DW] = r.outv[k];
    end
    drain_c = -1;
    for (int c = 0; c < 40 && drain_c < 0; c++) begin
      for (int k = 0; k < NN; k++) bus_if.layer_o_valid[k] = (r.dly[k] == 8'(c));
      step();
      bus_if.layer_o_valid = '0;
      if (bus_if.m_valid) drain_c = c;
    end
    if (r.exp_err[0]) ok = (drain_c == TO - 1);
    else              ok = (drain_c >= maxd) && (drain_c <= maxd + 1);
    chk("drain_entry", ok, 1'b1);
    chk("err_at_drain", err, r.exp_err);
    // Drain phase
    got        = 0;
    prev_stall = 1'b0;
    prev_d     = '0;
    for (cyc = 0; cyc < 40 && got < NN; cyc++) begin
      bus_if.m_ready = !(cyc >= int'(r.stall_at) && cyc < int'(r.stall_at) + int'(r.stall_len));
      if (prev_stall) begin
        chk("hold_valid", bus_if.m_valid, 1'b1);
        chk("hold_data", bus_if.m_data, prev_d);
      end
      if (bus_if.m_valid && bus_if.m_ready) begin
        gd[got] = bus_if.m_data;
        gl[got] = bus_if.m_last;
        got++;
      end
      prev_stall = bus_if.m_valid && !bus_if.m_ready;
      prev_d     = bus_if.m_data;
      step();
    end
    bus_if.m_ready = 1'b0;
    chk("drain_count", got, NN);
    for (int j = 0; j < got; j++) begin
      chk("m_data", gd[j], r.expm[j]);
      chk("m_last", gl[j], (j == NN - 1));
    end
    chk("back_to_feed", {bus_if.m_valid, busy, bus_if.s_ready}, 3'b001);
    chk("x_pulses", xcnt, NW);
    chk("err_end", err, r.exp_err);
  endtask

  initial begin
    // 1: constant valid, all neurons at once
    vec[0] = '{samp: {16'd3, 16'd2, 16'd1}, toggle: 1'b0,
               dly: {8'd0, 8'd0, 8'd0, 8'd0},
               outv: {16'd40, 16'd30, 16'd20, 16'd10},
               stall_at: 8'd0, stall_len: 8'd0,
               expm: {16'd40, 16'd30, 16'd20, 16'd10}, exp_err: 2'b00};
    // 2: toggling s_valid
    vec[1] = '{samp: {16'd7, 16'd6, 16'd5}, toggle: 1'b1,
               dly: {8'd2, 8'd2, 8'd2, 8'd2},
               outv: {16'h0044, 16'h0033, 16'h0022, 16'h0011},
               stall_at: 8'd0, stall_len: 8'd0,
               expm: {16'h0044, 16'h0033, 16'h0022, 16'h0011}, exp_err: 2'b00};
    // 3: staggered completion, neuron 3 first, neuron 0 last
    vec[2] = '{samp: {16'h0C0C, 16'h0B0B, 16'h0A0A}, toggle: 1'b0,
               dly: {8'd0, 8'd2, 8'd4, 8'd6},
               outv: {16'd400, 16'd300, 16'd200, 16'd100},
               stall_at: 8'd0, stall_len: 8'd0,
               expm: {16'd400, 16'd300, 16'd200, 16'd100}, exp_err: 2'b00};
    // 4: m_ready low for 5 cycles after the first transfer
    vec[3] = '{samp: {16'hFFFF, 16'h8000, 16'h0001}, toggle: 1'b0,
               dly: {8'd1, 8'd1, 8'd1, 8'd1},
               outv: {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA},
               stall_at: 8'd1, stall_len: 8'd5,
               expm: {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, exp_err: 2'b00};
    // 5: neuron 2 never completes -> timeout, zero in its slot
    vec[4] = '{samp: {16'd30, 16'd20, 16'd10}, toggle: 1'b0,
               dly: {8'd5, 8'd255, 8'd3, 8'd0},
               outv: {16'd10, 16'd9, 16'd8, 16'd7},
               stall_at: 8'd0, stall_len: 8'd0,
               expm: {16'd10, 16'd0, 16'd8, 16'd7}, exp_err: 2'b01};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      run_pass(vec[v]);
    end

    // 6a: o_valid in FEED flags err[1] and leaves the state alone
    do_reset();
    bus_if.layer_o_valid = 4'b0010;
    step();
    bus_if.layer_o_valid = '0;
    chk("err1_feed", err, 2'b10);
    chk("feed_after_ovalid", {busy, bus_if.s_ready}, 2'b01);

    // 6b: reset asserted in the middle of WAIT
    bus_if.s_valid = 1'b1;
    for (int n = 0; n < NW; n++) begin
      bus_if.s_data = 16'(n + 9);
      step();
    end
    bus_if.s_valid = 1'b0;
    chk("wait6_busy", {busy, bus_if.s_ready}, 2'b10);
    bus_if.layer_x_out   = 64'h1;
    bus_if.layer_o_valid = 4'b0001;
    step();
    bus_if.layer_o_valid = '0;
    step();
    chk("wait6_still", {busy, bus_if.m_valid}, 2'b10);
    rst = 1'b0;
    #1;
    chk("midrst_outs", {bus_if.s_ready, bus_if.m_valid, bus_if.m_last, busy, err}, 6'b0);
    chk("midrst_xvalid", bus_if.layer_x_valid, 4'h0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_feed", {bus_if.s_ready, busy, err}, 4'b1000);

    // 6c: a clean pass straight after the mid-pass reset
    run_pass(vec[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
